hwpe_ctrl_periph_arbiter: RTL

- Round-robin arbiter that shares one HWPE peripheral (register-file slave) between NB_MASTERS peripheral-bus masters, e.g. a cluster core port and a debug/DMA port.
- Sits between the masters and the slave port of the HWPE control slave.
- Holds a pending request stable until the slave grants it.
- Routes each single-cycle-latency response back to the master that issued it.

---
 rtl/hwpe_ctrl_periph_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hwpe_ctrl_periph_arbiter.sv
// Round-robin arbiter sharing one HWPE peripheral slave among
// NB_MASTERS peripheral-bus masters, with single-stage response routing.
module hwpe_ctrl_periph_arbiter #(
   parameter int NB_MASTERS = 2,
   parameter int ID_WIDTH   = 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic [NB_MASTERS-1:0]                mst_req_i,
   output logic [NB_MASTERS-1:0]                mst_gnt_o,
   input  logic [NB_MASTERS-1:0][31:0]          mst_add_i,
   input  logic [NB_MASTERS-1:0]                mst_wen_i,
   input  logic [NB_MASTERS-1:0][3:0]           mst_be_i,
   input  logic [NB_MASTERS-1:0][31:0]          mst_data_i,
   input  logic [NB_MASTERS-1:0][ID_WIDTH-1:0]  mst_id_i,
   output logic [31:0]                          mst_r_data_o,
   output logic [NB_MASTERS-1:0]                mst_r_valid_o,
   output logic [ID_WIDTH-1:0]                  mst_r_id_o,
   output logic                                 slv_req_o,
   input  logic                                 slv_gnt_i,
   output logic [31:0]                          slv_add_o,
   output logic                                 slv_wen_o,
   output logic [3:0]                           slv_be_o,
   output logic [31:0]                          slv_data_o,
   output logic [ID_WIDTH-1:0]                  slv_id_o,
   input  logic [31:0]                          slv_r_data_i,
   input  logic                                 slv_r_valid_i,
   input  logic [ID_WIDTH-1:0]                  slv_r_id_i
);

   localparam int IDX_WIDTH = $clog2(NB_MASTERS);

   localparam logic [0:0] ARB    = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   logic [0:0]           state_q;
   logic [IDX_WIDTH-1:0] rr_ptr_q;
   logic [IDX_WIDTH-1:0] lock_idx_q;
   logic [IDX_WIDTH-1:0] resp_idx_q;
   logic                 resp_pending_q;

   logic [IDX_WIDTH-1:0] rr_winner;
   logic [IDX_WIDTH-1:0] cand_idx;
   logic [IDX_WIDTH-1:0] sel_idx;
   logic [IDX_WIDTH-1:0] next_ptr;
   logic                 any_req;
   logic                 req_ok;
   logic                 grant;
   int                   cand;

   // Scan downward so the lowest offset from rr_ptr_q is assigned last.
   always_comb begin
      rr_winner = rr_ptr_q;
      cand      = 0;
      cand_idx  = '0;
      for (int k = NB_MASTERS - 1; k >= 0; k--) begin
         cand = int'(rr_ptr_q) + k;
         if (cand >= NB_MASTERS) cand = cand - NB_MASTERS;
         cand_idx = IDX_WIDTH'(cand);
         if (mst_req_i[cand_idx]) rr_winner = cand_idx;
      end
   end

   assign any_req = |mst_req_i;
   assign sel_idx = (state_q == LOCKED) ? lock_idx_q : rr_winner;
   assign req_ok  = (state_q == LOCKED) ? mst_req_i[lock_idx_q] : any_req;

   assign slv_req_o = req_ok & ~rst_i;
   assign grant     = slv_req_o & slv_gnt_i;

   assign next_ptr = (sel_idx == IDX_WIDTH'(NB_MASTERS - 1)) ?
                     '0 : sel_idx + 1'b1;

   assign slv_add_o  = mst_add_i[sel_idx];
   assign slv_wen_o  = mst_wen_i[sel_idx];
   assign slv_be_o   = mst_be_i[sel_idx];
   assign slv_data_o = mst_data_i[sel_idx];
   assign slv_id_o   = mst_id_i[sel_idx];

   always_comb begin
      mst_gnt_o          = '0;
      mst_gnt_o[sel_idx] = grant;
   end

   always_comb begin
      mst_r_valid_o             = '0;
      mst_r_valid_o[resp_idx_q] = slv_r_valid_i & resp_pending_q & ~rst_i;
   end

   assign mst_r_data_o = slv_r_data_i;
   assign mst_r_id_o   = slv_r_id_i;

   // A locked master that drops its request falls back to ARB ungranted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= ARB;
         rr_ptr_q       <= '0;
         lock_idx_q     <= '0;
         resp_idx_q     <= '0;
         resp_pending_q <= 1'b0;
      end else begin
         resp_pending_q <= grant;
         if (grant) begin
            resp_idx_q <= sel_idx;
            rr_ptr_q   <= next_ptr;
            state_q    <= ARB;
         end else if (state_q == ARB && any_req) begin
            lock_idx_q <= rr_winner;
            state_q    <= LOCKED;
         end else if (state_q == LOCKED && !mst_req_i[lock_idx_q]) begin
            state_q    <= ARB;
         end
      end
   end

   a_gnt_onehot : assert property (
      @(posedge clk_i) $onehot0(mst_gnt_o));

   a_rvalid_onehot : assert property (
      @(posedge clk_i) $onehot0(mst_r_valid_o));

   a_req_held : assert property (
      @(posedge clk_i) disable iff (rst_i)
      (state_q == LOCKED) |-> mst_req_i[lock_idx_q]);

   a_no_unsolicited : assert property (
      @(posedge clk_i) disable iff (rst_i)
      slv_r_valid_i |-> resp_pending_q);

endmodule
